change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Sequential return path of the vending machine: takes the accumulated credit and the item price, computes the change, and releases it to the coin ejector one coin at a time.
- Uses a valid/ack handshake and always pays the largest coin first (dime before nickel).
- Sits after the credit accumulator and before the ejector mechanism.
- All amounts are in nickel units: nickel = 1, dime = 2.

Parameters:
- W, 3: width of credit, price and remaining-change values.
- DIME_VAL, 2: dime value in nickel units.
- NICKEL_VAL, 1: nickel value in nickel units.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  one-cycle request to dispense change. Sampled only in IDLE.
- i_sum  input  W  accumulated credit, sampled with i_start.
- i_price  input  W  item price, sampled with i_start.
- i_coin_ack  input  1  ejector accepted the presented coin.
- o_coin_valid  output  1  a coin is presented on o_coin.
- o_coin  output  2  one-hot coin: 2'b01 = nickel, 2'b10 = dime, 2'b00 when not valid.
- o_change_left  output  W  change still owed.
- o_busy  output  1  high in DISPENSE and DONE.
- o_done  output  1  one-cycle pulse when change is fully paid (zero-change case included).
- o_err  output  1  one-cycle pulse when credit is below price.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: all outputs 0; internal remaining register 0; state IDLE.
- States: IDLE, DISPENSE, DONE. All outputs are registered or decoded from state/registers only; no combinational path from i_coin_ack to outputs.
- Arithmetic: difference is computed at W+1 bits; the borrow bit means i_sum < i_price. The stored remaining value is W bits and is never negative.
- IDLE, i_start=1 at edge N:
  - sum < price: o_err=1 in cycle N+1 only; stay IDLE; no coin, no o_done.
  - sum == price: go to DONE; o_done=1 in cycle N+1.
  - sum > price: remaining = sum - price; go to DISPENSE. o_coin_valid=1 in cycle N+1.
- DISPENSE:
  - o_coin = dime if remaining >= DIME_VAL, else nickel.
  - o_change_left = remaining.
  - o_coin and o_change_left hold stable while i_coin_ack=0 (stall for any duration).
- Edge with o_coin_valid=1 and i_coin_ack=1:
  - remaining -= value of the presented coin.
  - New value 0: go to DONE; o_coin_valid=0 next cycle.
  - Otherwise stay in DISPENSE; o_coin_valid stays high and the next coin is presented the following cycle, so back-to-back acks give one coin per cycle.
- DONE: o_done=1 for exactly one cycle, o_busy=1, then IDLE.
- i_start while o_busy=1: ignored; no state change; i_sum/i_price are not re-sampled.
- i_coin_ack while o_coin_valid=0: ignored.
- i_start and i_rst in the same cycle: reset wins.
- Reset mid-DISPENSE or in DONE: next cycle is IDLE with all outputs 0. Any pending change is discarded and no o_done is produced.
- Maximum W=3 case: sum=7, price=0 gives 3 dimes and 1 nickel, 4 handshakes.

Test Plan:
- sum=7, price=2, ack held high → coins dime, dime, nickel on consecutive cycles; o_change_left goes 5, 3, 1; o_done pulses on the cycle after the last ack; o_busy falls the cycle after that.
- sum=3, price=5 → o_err=1 for exactly one cycle after start; o_coin_valid, o_done and o_busy stay 0.
- sum=4, price=4 → o_done=1 for exactly one cycle after start; o_coin_valid never asserts.
- sum=6, price=3, ack low for 5 cycles then high → dime held stable with o_change_left=3 for all stall cycles; then nickel; then o_done.
- sum=7, price=1: after the first dime ack, assert i_rst for one cycle → next cycle o_coin_valid=0, o_change_left=0, IDLE; no o_done.
- During DISPENSE (sum=5, price=1), pulse i_start with sum=7, price=0 → ignored; coins dime, dime only; o_done once.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: computes credit minus price and releases the change one coin
// per valid/ack handshake, largest coin first.
module change_dispenser #(
    parameter int W          = 3,
    parameter int DIME_VAL   = 2,
    parameter int NICKEL_VAL = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_sum,
    input  logic [W-1:0] i_price,
    input  logic         i_coin_ack,
    output logic         o_coin_valid,
    output logic [1:0]   o_coin,
    output logic [W-1:0] o_change_left,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    typedef enum logic [1:0] {
        IDLE,
        DISPENSE,
        DONE
    } state_t;

    localparam logic [W-1:0] DIME_W   = W'(DIME_VAL);
    localparam logic [W-1:0] NICKEL_W = W'(NICKEL_VAL);

    state_t       state, state_next;
    logic [W-1:0] remaining, remaining_next;
    logic         err_q, err_next;
    logic [W:0]   diff;
    logic         pay_dime;
    logic [W-1:0] coin_val;

    // Extra top bit acts as the borrow flag: set when credit is below price.
    assign diff     = {1'b0, i_sum} - {1'b0, i_price};
    assign pay_dime = (remaining >= DIME_W);
    assign coin_val = pay_dime ? DIME_W : NICKEL_W;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            remaining <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            err_q     <= err_next;
        end
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        err_next       = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (diff[W]) begin
                        err_next = 1'b1;
                    end else if (diff[W-1:0] == '0) begin
                        state_next = DONE;
                    end else begin
                        remaining_next = diff[W-1:0];
                        state_next     = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                if (i_coin_ack) begin
                    remaining_next = remaining - coin_val;
                    if (remaining == coin_val) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next     = IDLE;
                remaining_next = '0;
            end
        endcase
    end

    always_comb begin
        o_coin = 2'b00;
        if (state == DISPENSE) begin
            o_coin = pay_dime ? 2'b10 : 2'b01;
        end
    end

    assign o_coin_valid  = (state == DISPENSE);
    assign o_change_left = remaining;
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == DONE);
    assign o_err         = err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a coin-queue
// reference model: each request expands into the list of coins still owed.
module tb_change_dispenser;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst, start, ack;
    logic [W-1:0] sum, price;
    logic         coin_valid, busy, done, err;
    logic [1:0]   coin;
    logic [W-1:0] change_left;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of coin values (2 = dime, 1 = nickel) still owed.
    int q[$];
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    change_dispenser #(.W(W), .DIME_VAL(2), .NICKEL_VAL(1)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_sum         (sum),
        .i_price       (price),
        .i_coin_ack    (ack),
        .o_coin_valid  (coin_valid),
        .o_coin        (coin),
        .o_change_left (change_left),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_update();
        bit was_busy;
        bit new_done;
        int d;
        if (rst) begin
            q.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end else begin
            was_busy = (q.size() > 0) || m_done;
            new_done = 1'b0;
            m_err    = 1'b0;
            if (!was_busy && start) begin
                d = int'(sum) - int'(price);
                if (d < 0) begin
                    m_err = 1'b1;
                end else if (d == 0) begin
                    new_done = 1'b1;
                end else begin
                    repeat (d / 2) q.push_back(2);
                    if (d % 2 == 1) q.push_back(1);
                end
            end else if (q.size() > 0 && ack) begin
                void'(q.pop_front());
                if (q.size() == 0) new_done = 1'b1;
            end
            m_done = new_done;
        end
    endtask

    task automatic compare_all();
        int owed;
        int exp_coin;
        owed = 0;
        foreach (q[i]) owed += q[i];
        exp_coin = 0;
        if (q.size() > 0) exp_coin = (q[0] == 2) ? 2 : 1;  // 2'b10 dime, 2'b01 nickel
        check("coin_valid",  int'(coin_valid),  int'(q.size() > 0));
        check("coin",        int'(coin),        exp_coin);
        check("change_left", int'(change_left), owed);
        check("busy",        int'(busy),        int'((q.size() > 0) || m_done));
        check("done",        int'(done),        int'(m_done));
        check("err",         int'(err),         int'(m_err));
    endtask

    task automatic step(input bit r, input bit s, input int sm, input int pr, input bit a);
        rst   = r;
        start = s;
        sum   = W'(sm);
        price = W'(pr);
        ack   = a;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; sum = '0; price = '0;
        step(1, 1, 7, 0, 1);
        step(1, 0, 0, 0, 0);
        check("reset_idle_change", int'(change_left), 0);

        // 7 - 2 with ack held: dime, dime, nickel, then done
        step(0, 1, 7, 2, 1);
        check("seq1_first_dime", int'(coin), 2);
        check("seq1_left5", int'(change_left), 5);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("seq1_nickel", int'(coin), 1);
        step(0, 0, 0, 0, 1);
        check("seq1_done", int'(done), 1);
        step(0, 0, 0, 0, 0);
        check("seq1_busy_low", int'(busy), 0);

        // underpay
        step(0, 1, 3, 5, 0);
        check("underpay_err", int'(err), 1);
        step(0, 0, 0, 0, 0);
        check("underpay_err_once", int'(err), 0);

        // exact payment
        step(0, 1, 4, 4, 0);
        check("exact_done", int'(done), 1);
        step(0, 0, 0, 0, 0);

        // stall with dime presented
        step(0, 1, 6, 3, 0);
        repeat (5) begin
            step(0, 0, 0, 0, 0);
            check("stall_dime", int'(coin), 2);
            check("stall_left3", int'(change_left), 3);
        end
        step(0, 0, 0, 0, 1);
        check("after_stall_nickel", int'(coin), 1);
        step(0, 0, 0, 0, 1);
        check("stall_done", int'(done), 1);
        step(0, 0, 0, 0, 0);

        // reset mid-dispense discards the change
        step(0, 1, 7, 1, 0);
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        check("rst_mid_valid", int'(coin_valid), 0);
        step(0, 0, 0, 0, 0);
        check("rst_mid_no_done", int'(done), 0);

        // start while busy is ignored
        step(0, 1, 5, 1, 0);
        step(0, 1, 7, 0, 1);
        step(0, 1, 7, 0, 1);
        check("busy_ignore_done", int'(done), 1);
        step(0, 0, 0, 0, 0);
        check("busy_ignore_idle", int'(busy), 0);

        // maximum change: 7 - 0 = three dimes and a nickel
        step(0, 1, 7, 0, 1);
        check("max_left7", int'(change_left), 7);
        repeat (4) step(0, 0, 0, 0, 1);
        check("max_done", int'(done), 1);
        step(0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 35),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 55));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
